reduce_width_sat_pipe: RTL

//  Multi-channel pipelined width reducer for signed sample streams. Per channel:

---
 rtl/reduce_width_sat_pipe.sv | 118 +++++++++++
 1 files changed

// File: rtl/reduce_width_sat_pipe.sv
// Multi-channel signed width reducer: round away SHIFT LSBs, then saturate to OWIDTH bits.
// Two-stage pipeline with sticky saturation flags; define SAT_COUNT_EN to add the sat_count counter.
module reduce_width_sat_pipe #(
  parameter int NCHAN  = 4,
  parameter int IWIDTH = 24,
  parameter int OWIDTH = 16,
  parameter int SHIFT  = 4,
  parameter int CWIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              rnd_mode,
  input  logic                    in_valid,
  input  logic [NCHAN*IWIDTH-1:0] in_data,
  input  logic                    sat_clr,
  output logic                    out_valid,
  output logic [NCHAN*OWIDTH-1:0] out_data,
  output logic [NCHAN-1:0]        sat_flags
`ifdef SAT_COUNT_EN
  ,
  output logic [CWIDTH-1:0]       sat_count
`endif
);

  // Rounded value carries one guard bit so rounding up never wraps.
  localparam int RW = IWIDTH - SHIFT + 1;

  logic [RW-1:0]     rnd     [NCHAN];
  logic [RW-1:0]     s1_r    [NCHAN];
  logic [OWIDTH-1:0] sat_val [NCHAN];
  logic [NCHAN-1:0]  sat_hit;
  logic              s1_valid;

  for (genvar k = 0; k < NCHAN; k++) begin : g_chan
    logic [IWIDTH-1:0] x;
    logic [RW-OWIDTH:0] top;

    assign x = in_data[k*IWIDTH +: IWIDTH];

    if (SHIFT > 0) begin : g_rnd
      logic [SHIFT-1:0] dropped;
      logic [RW-1:0]    fl;
      logic             rest;
      logic             up;

      assign dropped = x[SHIFT-1:0];
      assign fl      = {x[IWIDTH-1], x[IWIDTH-1:SHIFT]};
      // Any dropped bit below the half position is set, i.e. strictly above one half when the MSB is set.
      assign rest    = |(dropped << 1);

      always_comb begin
        up = 1'b0;
        case (rnd_mode)
          2'd1:    up = dropped[SHIFT-1];
          2'd2:    up = dropped[SHIFT-1] & (rest | fl[0]);
          default: up = 1'b0;
        endcase
      end

      assign rnd[k] = fl + {{(RW-1){1'b0}}, up};
    end else begin : g_pass
      assign rnd[k] = {x[IWIDTH-1], x};
    end

    // Value fits when every bit from the output sign bit upward agrees.
    assign top        = s1_r[k][RW-1:OWIDTH-1];
    assign sat_hit[k] = ~((&top) | ~(|top));
    assign sat_val[k] = !sat_hit[k] ? s1_r[k][OWIDTH-1:0] :
                        (s1_r[k][RW-1] ? {1'b1, {(OWIDTH-1){1'b0}}}
                                       : {1'b0, {(OWIDTH-1){1'b1}}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      for (int k = 0; k < NCHAN; k++) s1_r[k] <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        for (int k = 0; k < NCHAN; k++) s1_r[k] <= rnd[k];
      end
    end
  end

  logic [NCHAN-1:0] new_flags;
  assign new_flags = s1_valid ? sat_hit : '0;

  // A clear coinciding with a new saturation keeps the new event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sat_flags <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        for (int k = 0; k < NCHAN; k++) out_data[k*OWIDTH +: OWIDTH] <= sat_val[k];
      end
      sat_flags <= (sat_clr ? '0 : sat_flags) | new_flags;
    end
  end

`ifdef SAT_COUNT_EN
  logic sat_event;
  assign sat_event = |new_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= sat_event ? CWIDTH'(1) : '0;
    end else if (sat_event && !(&sat_count)) begin
      sat_count <= sat_count + CWIDTH'(1);
    end
  end
`endif

endmodule
